// File: rtl/cnt_ud_ctrl.sv
// Command controller for an up/down loadable counter: holds the counter by
// reloading its own value, and runs it for exactly N cycles on STEP commands.
module cnt_ud_ctrl #(
   parameter int WIDTH = 4,
   parameter int WRAPW = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_count,
   output logic [WRAPW-1:0] rsp_wraps,
   output logic [WIDTH-1:0] cnt_load,
   output logic             cnt_load_en,
   output logic             cnt_down,
   input  logic [WIDTH-1:0] cnt_count,
   input  logic             cnt_rollover
);

   typedef enum logic [1:0] {HOLD, LOAD_S, RUN, RESP} state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DN   = 2'b10;

   state_t           state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] arg_q;
   logic [WIDTH-1:0] remaining;
   logic [WRAPW-1:0] wraps_q;

   logic             accept;
   logic             wrap_hit;
   logic [WRAPW-1:0] wraps_nxt;
   logic [WIDTH-1:0] step_nxt;

   assign accept = cmd_valid & cmd_ready;

   // The wrap is judged on the pre-edge value: all-ones going up, zero going down.
   assign wrap_hit  = (state == RUN) &&
                      ((op_q == OP_DN) ? (cnt_count == '0) : cnt_rollover);
   assign wraps_nxt = (wrap_hit && (wraps_q != {WRAPW{1'b1}})) ? wraps_q + WRAPW'(1)
                                                                : wraps_q;
   // Value the counter takes on the final RUN edge, so the response can be registered.
   assign step_nxt  = (op_q == OP_DN) ? cnt_count - WIDTH'(1) : cnt_count + WIDTH'(1);

   // Outside LOAD_S the counter reloads its own value, freezing it.
   assign cnt_load  = (state == LOAD_S) ? arg_q : cnt_count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= HOLD;
         op_q        <= '0;
         arg_q       <= '0;
         remaining   <= '0;
         wraps_q     <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_count   <= '0;
         rsp_wraps   <= '0;
         cnt_load_en <= 1'b1;
         cnt_down    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         cmd_ready <= 1'b0;
         case (state)
            HOLD: begin
               if (accept) begin
                  op_q    <= cmd_op;
                  arg_q   <= cmd_arg;
                  wraps_q <= '0;
                  if (cmd_op == OP_LOAD) begin
                     state <= LOAD_S;
                  end else if ((cmd_op == OP_UP || cmd_op == OP_DN) && cmd_arg != '0) begin
                     state       <= RUN;
                     remaining   <= cmd_arg;
                     cnt_load_en <= 1'b0;
                     cnt_down    <= (cmd_op == OP_DN);
                  end else begin
                     // READ or a zero-length step answers straight away.
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_count <= cnt_count;
                     rsp_wraps <= '0;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            LOAD_S: begin
               state     <= RESP;
               wraps_q   <= '0;
               rsp_valid <= 1'b1;
               rsp_count <= arg_q;
               rsp_wraps <= '0;
            end
            RUN: begin
               remaining <= remaining - WIDTH'(1);
               wraps_q   <= wraps_nxt;
               if (remaining == WIDTH'(1)) begin
                  state       <= RESP;
                  rsp_valid   <= 1'b1;
                  rsp_count   <= step_nxt;
                  rsp_wraps   <= wraps_nxt;
                  cnt_load_en <= 1'b1;
                  cnt_down    <= 1'b0;
               end
            end
            default: begin
               state     <= HOLD;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_ud_ctrl.sv
// Bench for cnt_ud_ctrl with a behavioural up/down counter attached.
module tb_cnt_ud_ctrl;
   localparam int W  = 4;
   localparam int WW = 8;
   localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DN = 2'b10, OP_RD = 2'b11;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [W-1:0]  cmd_arg = '0;
   logic          rsp_valid;
   logic [W-1:0]  rsp_count;
   logic [WW-1:0] rsp_wraps;
   logic [W-1:0]  cnt_load;
   logic          cnt_load_en;
   logic          cnt_down;
   logic [W-1:0]  cnt_count;
   logic          cnt_rollover;

   always #5 clk = ~clk;

   cnt_ud_ctrl #(.WIDTH(W), .WRAPW(WW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_count(rsp_count), .rsp_wraps(rsp_wraps),
      .cnt_load(cnt_load), .cnt_load_en(cnt_load_en), .cnt_down(cnt_down),
      .cnt_count(cnt_count), .cnt_rollover(cnt_rollover)
   );

   // Counter model
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            cnt_count <= '0;
      else if (cnt_load_en) cnt_count <= cnt_load;
      else if (cnt_down)    cnt_count <= cnt_count - 4'd1;
      else                  cnt_count <= cnt_count + 4'd1;
   end
   assign cnt_rollover = &cnt_count;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Issue one command; returns response fields, latency k and cycles with cnt_down=1.
   task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] arg,
                         output logic [W-1:0] rc, output logic [WW-1:0] rw,
                         output int lat, output int dn);
      int t;
      lat = -1; dn = 0; rc = '0; rw = '0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      if (!cmd_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=no_ready expected=ready");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         dn += int'(cnt_down);
         if (rsp_valid) begin
            lat = k; rc = rsp_count; rw = rsp_wraps;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  arg;
      logic [W-1:0]  cnt;
      logic [WW-1:0] wr;
      int            lat;
      int            dn;
   } vec_t;

   vec_t vt[14];

   initial begin
      logic [W-1:0]  rc;
      logic [WW-1:0] rw;
      int lat, dn, t, bad_ready, step_at, read_at, seen;

      vt[0]  = '{OP_LOAD, 4'hE, 4'hE, 8'd0, 1, 0};
      vt[1]  = '{OP_UP,   4'd3, 4'h1, 8'd1, 3, 0};
      vt[2]  = '{OP_LOAD, 4'h2, 4'h2, 8'd0, 1, 0};
      vt[3]  = '{OP_DN,   4'd15, 4'h3, 8'd1, 15, 15};
      vt[4]  = '{OP_LOAD, 4'h5, 4'h5, 8'd0, 1, 0};
      vt[5]  = '{OP_UP,   4'd0, 4'h5, 8'd0, 0, 0};
      vt[6]  = '{OP_RD,   4'h7, 4'h5, 8'd0, 0, 0};
      vt[7]  = '{OP_DN,   4'd5, 4'h0, 8'd0, 5, 5};
      vt[8]  = '{OP_DN,   4'd1, 4'hF, 8'd1, 1, 1};
      vt[9]  = '{OP_UP,   4'd1, 4'h0, 8'd1, 1, 0};
      vt[10] = '{OP_LOAD, 4'hF, 4'hF, 8'd0, 1, 0};
      vt[11] = '{OP_UP,   4'd15, 4'hE, 8'd1, 15, 0};
      vt[12] = '{OP_DN,   4'd0, 4'hE, 8'd0, 0, 0};
      vt[13] = '{OP_RD,   4'h0, 4'hE, 8'd0, 0, 0};

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_count", 32'(rsp_count), 0);
      chk("rst_rsp_wraps", 32'(rsp_wraps), 0);
      chk("rst_load_en",   32'(cnt_load_en), 1);
      chk("rst_load",      32'(cnt_load), 0);
      chk("rst_down",      32'(cnt_down), 0);
      @(negedge clk);
      rstn = 1'b1;

      // LOAD 9 then counter must stay frozen while idle
      do_cmd(OP_LOAD, 4'h9, rc, rw, lat, dn);
      chk("load9_count", 32'(rc), 32'h9);
      chk("load9_wraps", 32'(rw), 0);
      chk("load9_lat", 32'(lat), 1);
      t = 0;
      repeat (10) begin
         @(negedge clk);
         if (cnt_count !== 4'h9 || cnt_load_en !== 1'b1) t++;
      end
      chk("idle_hold_bad_cycles", 32'(t), 0);

      for (int i = 0; i < 14; i++) begin
         do_cmd(vt[i].op, vt[i].arg, rc, rw, lat, dn);
         chk($sformatf("vec%0d_count", i), 32'(rc), 32'(vt[i].cnt));
         chk($sformatf("vec%0d_wraps", i), 32'(rw), 32'(vt[i].wr));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
         chk($sformatf("vec%0d_down_cycles", i), 32'(dn), 32'(vt[i].dn));
      end

      // cmd_valid held through STEP_UP 4 followed by READ
      do_cmd(OP_LOAD, 4'h3, rc, rw, lat, dn);
      chk("held_load3", 32'(rc), 32'h3);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd4;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      chk("held_ready_seen", 32'(cmd_ready), 1);
      @(posedge clk);
      bad_ready = 0; step_at = -1; read_at = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cmd_op = OP_RD; cmd_arg = '0;
         if (rsp_valid && step_at < 0) begin
            step_at = k;
            chk("held_step_count", 32'(rsp_count), 32'h7);
            chk("held_step_wraps", 32'(rsp_wraps), 0);
         end else if (rsp_valid && read_at < 0) begin
            read_at = k;
            chk("held_read_count", 32'(rsp_count), 32'h7);
            chk("held_read_wraps", 32'(rsp_wraps), 0);
            cmd_valid = 1'b0;
         end
         if ((step_at < 0 || k == step_at) && cmd_ready) bad_ready++;
      end
      cmd_valid = 1'b0;
      chk("held_ready_busy", 32'(bad_ready), 0);
      chk("held_step_at", 32'(step_at), 4);
      chk("held_read_at", 32'(read_at), 6);

      // Reset during the third cycle of STEP_UP 10
      do_cmd(OP_LOAD, 4'h6, rc, rw, lat, dn);
      chk("abort_load6", 32'(rc), 32'h6);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd10;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_count_before", 32'(cnt_count), 32'h8);
      rstn = 1'b0;
      #1;
      chk("abort_ready", 32'(cmd_ready), 0);
      chk("abort_cnt", 32'(cnt_count), 0);
      chk("abort_load_en", 32'(cnt_load_en), 1);
      chk("abort_down", 32'(cnt_down), 0);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      rstn = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("abort_no_rsp", 32'(seen), 0);
      do_cmd(OP_RD, 4'h0, rc, rw, lat, dn);
      chk("abort_read_count", 32'(rc), 0);
      chk("abort_read_wraps", 32'(rw), 0);
      chk("abort_read_lat", 32'(lat), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
